// File: rtl/crc32_hash_fold.sv
// crc32_hash_fold
//   Folds a KW-bit key into NB independent CRC-32 hashes (poly 0x04C11DB7,
//   non-reflected, no final XOR), CW key bits per cycle, MSB chunk first.
//   Bank b starts from SEED rotated left by b, so every bank gives a
//   different hash of the same key.
//
//   Optional feature: define CRC32_HASH_FOLD_CRC_OUT_EN to add out_crc,
//   which carries the full 32-bit CRC of every bank.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   clear             synchronous abort back to IDLE (beats in_valid/out_ready)
//   in_valid/in_ready key handshake, in_ready high only in IDLE
//   in_key[KW]        key, captured on acceptance
//   out_valid/out_ready result handshake, out_valid high only in HOLD
//   out_hash[NB*HW]   bank b hash at [b*HW +: HW]
//   out_crc[NB*32]    (optional) bank b CRC at [b*32 +: 32]

// One bank's CW-bit fold: CW serial CRC steps unrolled into combinational logic.
module crc32_hash_fold_lane #(
  parameter int CW = 16
) (
  input  logic [31:0]   i_crc,
  input  logic [CW-1:0] i_chunk,
  output logic [31:0]   o_crc
);
  localparam logic [31:0] POLY = 32'h04C11DB7;

  always_comb begin
    logic [31:0] c;
    logic        fb;
    c  = i_crc;
    fb = 1'b0;
    for (int i = CW-1; i >= 0; i--) begin
      fb = c[31] ^ i_chunk[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    o_crc = c;
  end
endmodule

module crc32_hash_fold #(
  parameter int          KW   = 64,
  parameter int          CW   = 16,
  parameter int          HW   = 5,
  parameter int          NB   = 2,
  parameter int          HIGH = 0,
  parameter logic [31:0] SEED = 32'h5AD795AD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [KW-1:0]      in_key,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NB*HW-1:0]   out_hash
`ifdef CRC32_HASH_FOLD_CRC_OUT_EN
  ,
  output logic [NB*32-1:0]   out_crc
`endif
);
  localparam int NCH  = KW / CW;
  localparam int CNTW = $clog2(NCH) + 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int b);
    logic [63:0] t;
    t = {x, x} << b;
    return t[63:32];
  endfunction

  state_t                r_state, w_next;
  logic                  w_load, w_step;
  logic [KW-1:0]         r_key;
  logic [CNTW-1:0]       r_cnt;
  logic [NB-1:0][31:0]   r_crc;
  logic [NB-1:0][31:0]   w_fold;
  logic [CW-1:0]         w_chunk;

  // The key register shifts left as chunks are consumed, so the next chunk
  // is always the top CW bits.
  assign w_chunk = r_key[KW-1 -: CW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = S_CALC;
          w_load = 1'b1;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_cnt == LAST) w_next = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort wins over any handshake in the same cycle; nothing is captured.
    if (clear) begin
      w_next = S_IDLE;
      w_load = 1'b0;
      w_step = 1'b0;
    end
  end

  // Counter is one bit wider than needed for NCH-1 so the final increment
  // lands on NCH instead of wrapping to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
      r_cnt <= '0;
      r_crc <= '0;
    end else if (w_load) begin
      r_key <= in_key;
      r_cnt <= '0;
      for (int b = 0; b < NB; b++) r_crc[b] <= rotl(SEED, b);
    end else if (w_step) begin
      r_key <= r_key << CW;
      r_cnt <= r_cnt + CNTW'(1);
      r_crc <= w_fold;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    crc32_hash_fold_lane #(.CW(CW)) u_lane (
      .i_crc   (r_crc[b]),
      .i_chunk (w_chunk),
      .o_crc   (w_fold[b])
    );
    if (HIGH != 0) begin : g_hi
      assign out_hash[b*HW +: HW] = r_crc[b][31 -: HW];
    end else begin : g_lo
      assign out_hash[b*HW +: HW] = r_crc[b][HW-1:0];
    end
  end

`ifdef CRC32_HASH_FOLD_CRC_OUT_EN
  // CRC registers only move in CALC, so they are stable through HOLD.
  assign out_crc = r_crc;
`endif

endmodule
